// File: rtl/kyber_pkg.sv
// kyber_pkg: Kyber constants, NTT controller states and modular arithmetic helpers
package kyber_pkg;
  localparam int Q = 3329;
  localparam int N = 256;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 8;
  localparam int PW = 2 * DATA_W;
  typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, WRITE, DONE} state_t;
  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= (DATA_W+1)'(Q) ? DATA_W'(s - (DATA_W+1)'(Q)) : DATA_W'(s);
  endfunction
  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W:0] d;
    d = {1'b0, a} + (DATA_W+1)'(Q) - {1'b0, b};
    return a >= b ? a - b : DATA_W'(d);
  endfunction
  function automatic logic [DATA_W-1:0] mod_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [PW-1:0] p;
    p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return DATA_W'(p % PW'(Q));
  endfunction
  function automatic logic [N-1:0][DATA_W-1:0] ram_init();
    logic [N-1:0][DATA_W-1:0] r;
    for (int i = 0; i < N; i++) r[i] = DATA_W'(i);
    return r;
  endfunction
endpackage

// File: rtl/kyber_ntt_ram.sv
// kyber_ntt_ram: true dual-port coefficient RAM, registered reads, powers up with mem[i] = i
module kyber_ntt_ram import kyber_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b
);
  logic [N-1:0][DATA_W-1:0] mem = ram_init();
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    if (we_b) mem[addr_b] <= wdata_b;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
    end
endmodule

// File: rtl/kyber_ntt_top.sv
// kyber_ntt_top: one in-place length-128 Cooley-Tukey NTT layer over the internal coefficient RAM
module kyber_ntt_top import kyber_pkg::*; #(
  parameter logic [DATA_W-1:0] TWIDDLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic [DATA_W-1:0] debug_ram_out_a,
  output logic [DATA_W-1:0] debug_ram_out_b
);
  state_t st;
  logic [6:0] j;
  logic [DATA_W-1:0] even, odd, t;
  logic we;
  assign t = mod_mul(debug_ram_out_b, TWIDDLE);
  assign done = st == DONE;
  assign we = st == WRITE && rst;
  always_ff @(posedge clk)
    if (!rst) begin
      st <= IDLE;
      j <= '0;
      even <= '0;
      odd <= '0;
    end else begin
      case (st)
        IDLE, DONE: if (start) begin
          st <= READ;
          j <= '0;
        end
        READ: st <= WAIT;
        WAIT: st <= CALC;
        CALC: begin
          even <= mod_add(debug_ram_out_a, t);
          odd <= mod_sub(debug_ram_out_a, t);
          st <= WRITE;
        end
        WRITE: begin
          st <= j == 7'd127 ? DONE : READ;
          j <= j + 7'd1;
        end
        default: st <= IDLE;
      endcase
    end
  kyber_ntt_ram ram_unit (
    .clk(clk),
    .rst(rst),
    .we_a(we),
    .we_b(we),
    .addr_a({1'b0, j}),
    .addr_b({1'b1, j}),
    .wdata_a(even),
    .wdata_b(odd),
    .q_a(debug_ram_out_a),
    .q_b(debug_ram_out_b)
  );
endmodule

// File: tb/tb_kyber_ntt_top.sv
// tb_kyber_ntt_top: randomized runs of two engines (twiddle 1 and 17) against a plain-arithmetic layer model
module tb_kyber_ntt_top;
  import kyber_pkg::*;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst0, start0, done0, rst1, start1, done1;
  logic [DATA_W-1:0] qa0, qb0, qa1, qb1;
  int tests = 0;
  int fails = 0;
  int m [2][256];
  logic exp_done [2];
  logic chk_en = 0;

  kyber_ntt_top dut0 (.clk(clk), .rst(rst0), .start(start0), .done(done0),
                      .debug_ram_out_a(qa0), .debug_ram_out_b(qb0));
  kyber_ntt_top #(.TWIDDLE(12'd17)) dut1 (.clk(clk), .rst(rst1), .start(start1), .done(done1),
                      .debug_ram_out_a(qa1), .debug_ram_out_b(qb1));

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic int get_mem(input int sel, input int i);
    return sel == 0 ? int'(dut0.ram_unit.mem[i]) : int'(dut1.ram_unit.mem[i]);
  endfunction

  function automatic void layer(input int sel, input int cnt);
    int tw, a, b, t;
    tw = sel == 0 ? 1 : 17;
    for (int k = 0; k < cnt; k++) begin
      a = m[sel][k];
      b = m[sel][k+128];
      t = (b * tw) % Q;
      m[sel][k] = (a + t) % Q;
      m[sel][k+128] = (a - t + Q) % Q;
    end
  endfunction

  task automatic set_in(input int sel, input logic s, input logic r);
    if (sel == 0) begin
      start0 = s;
      rst0 = r;
    end else begin
      start1 = s;
      rst1 = r;
    end
  endtask

  task automatic check_all(input int sel);
    for (int i = 0; i < 256; i++) chk($sformatf("mem%0d[%0d]", sel, i), get_mem(sel, i), m[sel][i]);
  endtask

  task automatic run(input int sel, input int rst_at, input int restart_at);
    set_in(sel, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    set_in(sel, 1'b0, 1'b1);
    exp_done[sel] = 0;
    for (int c = 1; c <= 512; c++) begin
      set_in(sel, c == restart_at, c != rst_at);
      @(posedge clk);
      #1;
      set_in(sel, 1'b0, 1'b1);
      if (c == rst_at) begin
        layer(sel, (c - 1) / 4);
        chk("rst_done", sel == 0 ? int'(done0) : int'(done1), 0);
        chk("rst_dbg_a", sel == 0 ? int'(qa0) : int'(qa1), 0);
        chk("rst_dbg_b", sel == 0 ? int'(qb0) : int'(qb1), 0);
        chk("rst_state", sel == 0 ? int'(dut0.st) : int'(dut1.st), int'(IDLE));
        check_all(sel);
        return;
      end
    end
    exp_done[sel] = 1;
    chk("done_at_512", sel == 0 ? int'(done0) : int'(done1), 1);
    layer(sel, 128);
    check_all(sel);
  endtask

  always @(negedge clk)
    if (chk_en) begin
      chk("done0_cycle", int'(done0), int'(exp_done[0]));
      chk("done1_cycle", int'(done1), int'(exp_done[1]));
    end

  initial begin
    int ra, sa;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) m[s][i] = i;
    exp_done[0] = 0;
    exp_done[1] = 0;
    rst0 = 0;
    rst1 = 0;
    start0 = 0;
    start1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done0", int'(done0), 0);
    chk("reset_qa0", int'(qa0), 0);
    chk("reset_qb0", int'(qb0), 0);
    chk("reset_done1", int'(done1), 0);
    chk("reset_qa1", int'(qa1), 0);
    rst0 = 1;
    rst1 = 1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    run(0, 0, 0);
    chk("tw1_mem0", get_mem(0, 0), 128);
    chk("tw1_mem128", get_mem(0, 128), 3201);
    chk("tw1_mem127", get_mem(0, 127), 382);
    chk("tw1_mem255", get_mem(0, 255), 3201);
    run(0, 0, 0);
    chk("tw1_second_mem0", get_mem(0, 0), 0);
    chk("tw1_second_mem128", get_mem(0, 128), 256);
    run(0, 0, 100);
    run(0, 200, 0);
    chk("rst_mem49_untouched", get_mem(0, 49) == m[0][49] ? 1 : 0, 1);
    run(0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      ra = $urandom_range(0, 1) ? int'($urandom_range(5, 511)) : 0;
      sa = $urandom_range(1, 512);
      if (sa == ra) sa = 0;
      run(0, ra, sa);
    end
    run(1, 0, 0);
    chk("tw17_mem0", get_mem(1, 0), 2176);
    chk("tw17_mem128", get_mem(1, 128), 1153);
    chk("tw17_mem127", get_mem(1, 127), 1133);
    chk("tw17_mem255", get_mem(1, 255), 2450);
    run(1, $urandom_range(5, 511), $urandom_range(1, 4));
    run(1, 0, $urandom_range(1, 512));
    repeat (3) @(posedge clk);
    #1;
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
